// File: rtl/tt_completion_fifo.sv
// tt_completion_fifo: buffers VPU retire records onto the OVI completion channel
// and paces freed issue-queue slots back to the core as one credit per cycle.
module tt_completion_fifo #(
  parameter int DEPTH = 4,
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vpu_done_valid,
  output logic                         vpu_done_ready,
  input  logic [4:0]                   vpu_done_sb_id,
  input  logic [63:0]                  vpu_done_dest_reg,
  input  logic [4:0]                   vpu_done_fflags,
  input  logic                         vpu_done_vxsat,
  input  logic                         vpu_done_illegal,
  input  logic                         completion_hold,
  output logic                         completion_valid,
  output logic [4:0]                   completion_sb_id,
  output logic [63:0]                  completion_dest_reg,
  output logic [4:0]                   completion_fflags,
  output logic                         completion_vxsat,
  output logic                         completion_illegal,
  input  logic                         free_valid,
  input  logic [$clog2(CREDITS):0]     free_cnt,
  output logic                         issue_credit
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS) + 1;
  localparam int RW = 5 + 64 + 5 + 1 + 1;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ph, rd_ph, full, empty, push, pop;
  logic [CW-1:0] cnt;
  logic [CW:0] cnt_sum;
  assign full = wr_ptr == rd_ptr && wr_ph != rd_ph;
  assign empty = wr_ptr == rd_ptr && wr_ph == rd_ph;
  assign vpu_done_ready = !full;
  assign push = vpu_done_valid && !full;
  assign pop = !empty && !completion_hold;
  assign cnt_sum = {1'b0, cnt} + (free_valid ? {1'b0, free_cnt} : {(CW+1){1'b0}})
                 - {{CW{1'b0}}, cnt != '0};
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {vpu_done_sb_id, vpu_done_dest_reg, vpu_done_fflags, vpu_done_vxsat, vpu_done_illegal};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_ph <= 1'b0;
      rd_ph <= 1'b0;
      cnt <= '0;
      completion_valid <= 1'b0;
      {completion_sb_id, completion_dest_reg, completion_fflags, completion_vxsat, completion_illegal} <= '0;
      issue_credit <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == AW'(DEPTH - 1)) wr_ph <= !wr_ph;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == AW'(DEPTH - 1)) rd_ph <= !rd_ph;
        {completion_sb_id, completion_dest_reg, completion_fflags, completion_vxsat, completion_illegal} <= mem[rd_ptr];
      end
      completion_valid <= pop;
      // overflow is a core protocol error; saturate so the counter never wraps
      cnt <= cnt_sum > (CW+1)'(CREDITS) ? CW'(CREDITS) : cnt_sum[CW-1:0];
      issue_credit <= cnt != '0;
    end
  credit_overflow: assert property (@(posedge clk) disable iff (!reset_n) cnt_sum <= (CW+1)'(CREDITS));
endmodule

// File: doc/tt_completion_fifo.md
# tt_completion_fifo

Return-path buffer between the Ocelot VPU and the OVI interface. Captures VPU retire records into a small FIFO, drives them onto the OVI completion channel one per cycle, and returns issue credits to the scalar core as issue-queue slots are freed, by retirement or by kill. It is the core-facing counterpart of the issue FIFO that feeds the VPU.

## Interface
Parameters:
- DEPTH, 4: completion FIFO entries; power of two, ≥2.
- CREDITS, 4: issue slots owned by the core-side issue FIFO; sets the credit counter range 0..CREDITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- vpu_done_valid  in  1  VPU presents a retire record.
- vpu_done_ready  out  1  FIFO accepts the record this cycle.
- vpu_done_sb_id  in  5  scoreboard id of the retiring instruction.
- vpu_done_dest_reg  in  64  scalar result (vmv.x.s, vfmv.f.s, vpopc and similar); 0 otherwise.
- vpu_done_fflags  in  5  accrued FP exception flags.
- vpu_done_vxsat  in  1  fixed-point saturation flag.
- vpu_done_illegal  in  1  instruction trapped as illegal.
- completion_hold  in  1  blocks emission this cycle (memory-sync ordering).
- completion_valid  out  1  OVI completion strobe.
- completion_sb_id  out  5  id of the completing instruction.
- completion_dest_reg  out  64  scalar result.
- completion_fflags  out  5  FP flags.
- completion_vxsat  out  1  saturation flag.
- completion_illegal  out  1  illegal flag.
- free_valid  in  1  issue-side slots were released this cycle.
- free_cnt  in  $clog2(CREDITS)+1  number of slots released; 1..CREDITS while free_valid is high.
- issue_credit  out  1  OVI issue credit pulse; one credit per high cycle.

## Operation
- FIFO: wr_ptr, rd_ptr, and one phase bit each. full = ptrs equal and phases differ; empty = ptrs equal and phases equal. Each phase bit toggles when its pointer wraps from DEPTH-1 to 0.
- vpu_done_ready = !full. Push on vpu_done_valid && vpu_done_ready; all record fields are stored.
- Emit: when the FIFO is non-empty and completion_hold is low, the head record is loaded into the registered completion_* outputs, completion_valid is 1 the next cycle, and rd_ptr advances. Otherwise completion_valid is 0 the next cycle.
- completion_* data fields hold their last values while completion_valid is low.
- Full with push and pop in the same cycle: ready is still 0 (decided from full alone). Push and pop to a non-full, non-empty FIFO in the same cycle: both happen and the occupancy count is unchanged.
- OVI completion has no back-pressure. Once completion_valid is high, the record is considered delivered.
- Credit counter cnt (0..CREDITS), next value per cycle: cnt + (free_valid ? free_cnt : 0) - (cnt != 0 ? 1 : 0). issue_credit is registered and equals (cnt != 0) from the previous cycle.
- Credits therefore drain at one per cycle, and a burst of kill-freed slots is spread over consecutive cycles.
- cnt must never exceed CREDITS. Overflow is a protocol error: flagged by a simulation assertion and saturated at CREDITS in RTL.

## Timing
- Reset (asynchronous assert, synchronous release): pointers, phases and cnt are 0. All outputs are 0 except vpu_done_ready, which is 1.
- Record accepted at edge N with the FIFO empty and hold low: completion_valid is high in cycle N+1→N+2, i.e. after 2 edges. A record pushed into an empty FIFO is not bypassed to the output.
- Sustained throughput is one completion per cycle while the FIFO is non-empty and hold is low.
- completion_hold is sampled at the pop edge only. A completion already driven is not withdrawn.
- free_valid at edge N with cnt=0: issue_credit is high in cycles N+1 .. N+free_cnt (registered).
- Reset asserted mid-operation: all buffered records and pending credits are discarded. Outputs drop to their reset values asynchronously.

## Test plan
- Single record: push sb_id=3, dest=0xDEAD_BEEF, fflags=0x01 into an empty FIFO with hold=0 → exactly one completion_valid pulse 2 cycles later carrying those values. issue_credit stays 0.
- Fill with hold=1, DEPTH=4: push ids 0..4 on consecutive cycles → ids 0..3 accepted; ready=0 while full, so id 4 is stalled. Release hold → completions 0,1,2,3 on 4 consecutive cycles, and id 4 is accepted the cycle after the first pop.
- Wrap: 10 back-to-back pushes with hold=0 → ids emitted in order with no gaps. Phase bits toggle at each wrap; never falsely full or empty.
- Hold toggling: hold pattern 1,0,1,0 with 2 entries buffered → completions appear only on hold-low pop edges, and no record is duplicated or lost.
- Credits: free_valid with free_cnt=3 at cycle 0, then free_cnt=1 at cycle 1 → issue_credit high for 4 consecutive cycles starting at cycle 1, then low.
- Async reset with 3 entries buffered and cnt=2 → completion_valid and issue_credit drop to 0 immediately. After release, no stale completions or credits appear.
